// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package data_mem_responder_pkg;

  localparam int WORD_W      = 32;
  localparam int SEL_W       = 4;
  localparam int DMEM_ADDR_W = 30;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Responder FSM encoding, also exported on the debug port.
  typedef enum logic [1:0] {
    DMEM_STATE_IDLE = 2'd0,
    DMEM_STATE_WAIT = 2'd1,
    DMEM_STATE_DONE = 2'd2
  } dmem_state_e;

  // Expand a byte-lane select into a 32-bit bit mask.
  function automatic logic [WORD_W-1:0] lane_mask(input logic [SEL_W-1:0] sel);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < SEL_W; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data memory request/response bundle between EX/MEM and the responder.
//
// Handshake: a request is offered whenever either enable is high. The
// responder holds mem_memStall high from the offering cycle until the access
// completes; the requester keeps all request inputs stable while stall is
// high. Completion is the single-cycle mem_memAck pulse (stall is low in that
// cycle), and the requester may present its next request on the very next
// cycle.
interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
);
  logic                mem_memWriteEnable;
  logic                mem_memReadEnable;
  logic [ADDR_W-1:0]   mem_memAddr;
  logic [SEL_W-1:0]    mem_memSel;
  logic [WORD_W-1:0]   mem_memWriteData;
  logic [WORD_W-1:0]   mem_memReadData;
  logic                mem_memStall;
  logic                mem_memAck;
  logic                mem_memErr;

  modport master (
    output mem_memWriteEnable, mem_memReadEnable, mem_memAddr, mem_memSel, mem_memWriteData,
    input  mem_memReadData, mem_memStall, mem_memAck, mem_memErr
  );

  modport slave (
    input  mem_memWriteEnable, mem_memReadEnable, mem_memAddr, mem_memSel, mem_memWriteData,
    output mem_memReadData, mem_memStall, mem_memAck, mem_memErr
  );
endinterface

// File: rtl/data_mem_responder_dmem_byte_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module data_mem_responder_dmem_byte_ram
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [SEL_W-1:0]      we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     q
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem [0:DEPTH-1];

  // Byte-lane writes and enabled synchronous read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SEL_W; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: accepts one word access per request,
// inserts WAIT_CYCLES wait states, stalls the pipeline meanwhile, and returns
// lane-masked read data with a one-cycle ack. Protocol and address problems
// raise a sticky error flag.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus,
  output dmem_state_e          state_dbg
);

  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  dmem_state_e state;
  dmem_state_e state_next;

  logic [CNT_W-1:0]      wait_cnt;
  logic [DEPTH_LOG2-1:0] cap_addr;
  logic [SEL_W-1:0]      cap_sel;
  logic [WORD_W-1:0]     cap_wdata;
  logic                  cap_write;
  logic                  err_q;
  logic [WORD_W-1:0]     rd_mask;

  logic [ADDR_W-1:0]     req_addr;
  logic                  req;
  logic                  both_en;
  logic                  addr_oob;
  logic                  accept;
  logic                  stall_c;
  logic                  ack_c;
  logic                  commit;

  logic [DEPTH_LOG2-1:0] acc_addr;
  logic [SEL_W-1:0]      acc_sel;
  logic [WORD_W-1:0]     acc_wdata;
  logic                  acc_write;

  logic [SEL_W-1:0]      ram_we;
  logic                  ram_re;
  logic [WORD_W-1:0]     ram_q;

  assign req_addr = bus.mem_memAddr;
  assign req      = bus.mem_memWriteEnable | bus.mem_memReadEnable;
  assign both_en  = bus.mem_memWriteEnable & bus.mem_memReadEnable;
  // Any address bit above the RAM index means the access aliases.
  assign addr_oob = (req_addr >> DEPTH_LOG2) != '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DMEM_STATE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, stall and ack decode.
  always_comb begin
    state_next = state;
    accept     = DISABLE;
    stall_c    = DISABLE;
    ack_c      = DISABLE;
    case (state)
      DMEM_STATE_IDLE: begin
        if (req) begin
          accept     = ENABLE;
          stall_c    = ENABLE;
          state_next = (WAIT_CYCLES == 0) ? DMEM_STATE_DONE : DMEM_STATE_WAIT;
        end
      end
      DMEM_STATE_WAIT: begin
        stall_c = ENABLE;
        if (wait_cnt == CNT_LAST) begin
          state_next = DMEM_STATE_DONE;
        end
      end
      DMEM_STATE_DONE: begin
        ack_c      = ENABLE;
        state_next = DMEM_STATE_IDLE;
      end
      default: begin
        state_next = DMEM_STATE_IDLE;
      end
    endcase
  end

  // Request capture, wait counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      cap_addr  <= '0;
      cap_sel   <= '0;
      cap_wdata <= '0;
      cap_write <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cap_addr  <= req_addr[DEPTH_LOG2-1:0];
        cap_sel   <= bus.mem_memSel;
        cap_wdata <= bus.mem_memWriteData;
        // Both enables resolve to a write.
        cap_write <= bus.mem_memWriteEnable;
        wait_cnt  <= '0;
        if (both_en || addr_oob) begin
          err_q <= 1'b1;
        end
      end else if (state == DMEM_STATE_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // With no wait states the access commits on the accepting edge, so the RAM
  // must see the live request; otherwise it sees the captured copy, which
  // makes input changes during the stall harmless.
  assign acc_addr  = (state == DMEM_STATE_IDLE) ? req_addr[DEPTH_LOG2-1:0] : cap_addr;
  assign acc_sel   = (state == DMEM_STATE_IDLE) ? bus.mem_memSel           : cap_sel;
  assign acc_wdata = (state == DMEM_STATE_IDLE) ? bus.mem_memWriteData     : cap_wdata;
  assign acc_write = (state == DMEM_STATE_IDLE) ? bus.mem_memWriteEnable   : cap_write;

  // The access happens on the edge entering DONE; never while reset is held.
  assign commit = rst_n & (state_next == DMEM_STATE_DONE);
  assign ram_we = (commit && acc_write) ? acc_sel : '0;
  assign ram_re = commit & ~acc_write;

  data_mem_responder_dmem_byte_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .q     (ram_q)
  );

  // Lane mask of the last completed read; zero after reset so read data
  // starts at 0 even though the RAM output register is not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_mask <= '0;
    end else if (ram_re) begin
      rd_mask <= lane_mask(acc_sel);
    end
  end

  assign bus.mem_memReadData = ram_q & rd_mask;
  assign bus.mem_memStall    = stall_c & rst_n;
  assign bus.mem_memAck      = ack_c;
  assign bus.mem_memErr      = err_q;
  assign state_dbg           = state;

endmodule
